// File: rtl/spi_slave_frame.sv
// SPI slave with framed receive, full-duplex transmit and a valid/ready output.
// sck, nss and sdi are synchronised into clk; all four CPOL/CPHA modes are supported.
module spi_slave_frame #(
    parameter int WIDTH       = 16,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             nss,
    input  logic             sdi,
    output logic             sdo,
    output logic             sdo_oe,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             rx_len_err
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] SAT = CW'(WIDTH + 1);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);
    localparam logic IDLE_LVL = (CPOL != 0);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] nss_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic sck_d;
    logic nss_d;

    logic sck_s;
    logic nss_s;
    logic sdi_s;
    logic sck_rise;
    logic sck_fall;
    logic nss_rise;
    logic nss_fall;
    logic sample_edge;
    logic shift_edge;
    logic frame_start;
    logic frame_end;
    logic in_frame;

    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] tx_sr;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] tx_left;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // Synchronise the SPI pins and keep a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= {SYNC_STAGES{IDLE_LVL}};
            nss_q <= '0;
            sdi_q <= '0;
            sck_d <= IDLE_LVL;
            nss_d <= 1'b0;
        end else begin
            sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
            nss_q <= {nss_q[SYNC_STAGES-2:0], nss};
            sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
            sck_d <= sck_q[SYNC_STAGES-1];
            nss_d <= nss_q[SYNC_STAGES-1];
        end
    end

    assign sck_s = sck_q[SYNC_STAGES-1];
    assign nss_s = nss_q[SYNC_STAGES-1];
    assign sdi_s = sdi_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign nss_rise = nss_s & ~nss_d;
    assign nss_fall = ~nss_s & nss_d;
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge = SAMPLE_RISE ? sck_fall : sck_rise;
    assign frame_start = (state == IDLE) && nss_fall;
    assign frame_end = (state == ACTIVE) && nss_rise;
    assign in_frame = (state == ACTIVE) && !nss_rise;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else state <= state_nx;
    end

    // Next-state: a frame interrupted by reset is skipped until nss goes high.
    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_IDLE: if (nss_s) state_nx = IDLE;
            IDLE:      if (nss_fall) state_nx = ACTIVE;
            ACTIVE:    if (nss_rise) state_nx = IDLE;
            default:   state_nx = WAIT_IDLE;
        endcase
    end

    // Shift registers, bit counting, frame-end delivery and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdo        <= 1'b0;
            sdo_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_len_err <= 1'b0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            bit_cnt    <= '0;
            tx_left    <= '0;
        end else begin
            rx_overrun <= 1'b0;
            rx_len_err <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (frame_start) begin
                bit_cnt <= '0;
                sdo_oe  <= 1'b1;
                if (CPHA == 0) begin
                    sdo     <= head(tx_data);
                    tx_sr   <= advance(tx_data);
                    tx_left <= CW'(WIDTH - 1);
                end else begin
                    sdo     <= 1'b0;
                    tx_sr   <= tx_data;
                    tx_left <= FULL;
                end
            end
            if (in_frame && sample_edge) begin
                if (MSB_FIRST != 0) rx_sr <= {rx_sr[WIDTH-2:0], sdi_s};
                else rx_sr <= {sdi_s, rx_sr[WIDTH-1:1]};
                if (bit_cnt != SAT) bit_cnt <= bit_cnt + CW'(1);
            end
            if (in_frame && shift_edge) begin
                if (tx_left != '0) begin
                    sdo     <= head(tx_sr);
                    tx_sr   <= advance(tx_sr);
                    tx_left <= tx_left - CW'(1);
                end else begin
                    sdo <= 1'b0;
                end
            end
            if (frame_end) begin
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
                if (bit_cnt == FULL) begin
                    if (!rx_valid || rx_ready) begin
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                    end else begin
                        rx_overrun <= 1'b1;
                    end
                end else begin
                    rx_len_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
- Parametrised SPI slave that succeeds the two-byte sck-clocked receiver.
- Runs entirely in the system clock domain: sck, nss and sdi are synchronised and edge-detected.
- Supports all four CPOL/CPHA modes, configurable frame width and bit order, and full-duplex transmit on sdo.
- Received frames go to downstream logic (dice/roll decode, seven-seg drivers) over a valid/ready handshake, with overrun and frame-length error reporting.

Parameters:
- WIDTH, 16: bits per frame (≥2).
- CPOL, 0: sck idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first on both sdi and sdo; 0 = LSB first.
- SYNC_STAGES, 2: flip-flop stages on sck/nss/sdi (≥2).

Ports:
- clk  in  1  system clock; every flop in the block is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- sck  in  1  SPI clock, asynchronous to clk.
- nss  in  1  chip select, active low, asynchronous.
- sdi  in  1  serial data in (MOSI).
- sdo  out 1  serial data out (MISO).
- sdo_oe  out 1  1 while a frame is in progress (for tri-state pad).
- tx_data  in  WIDTH  word transmitted in the next frame.
- rx_data  out WIDTH  last accepted frame.
- rx_valid  out 1  rx_data holds an unconsumed frame.
- rx_ready  in  1  consumer accepts rx_data.
- rx_overrun  out 1  one-cycle pulse: complete frame dropped because rx_valid was held.
- rx_len_err  out 1  one-cycle pulse: frame ended with bit count ≠ WIDTH.

Behaviour:
- **Reset values:** sdo=0, sdo_oe=0, rx_data=0, rx_valid=0, rx_overrun=0, rx_len_err=0. Bit counter and shift registers clear; FSM goes to WAIT_IDLE.
- **Synchronisers:** sck, nss and sdi each pass through SYNC_STAGES flops. Edges are detected by comparing the last stage with a delay flop.
- **Clocking requirement:** sck high and low phases each ≥ SYNC_STAGES+2 clk periods; behaviour is undefined otherwise.
- **Edge assignment:**
  - Sample edge: rising sck when CPOL==CPHA, falling otherwise.
  - Shift edge: the opposite sck edge.
- **FSM:**
  - WAIT_IDLE → IDLE when synced nss=1. This means reset or an error mid-frame ignores the rest of that frame.
  - IDLE → ACTIVE on synced nss falling edge. In that cycle: tx_data is latched into the tx shift register, the bit counter is cleared, and sdo_oe is set to 1.
  - ACTIVE → IDLE on synced nss rising edge. Frame-end rules below apply in that cycle; sdo_oe goes to 0 and sdo goes to 0.
- **Receive:**
  - Each sample edge shifts sdi into the rx shift register: at the LSB end if MSB_FIRST=1, at the MSB end otherwise.
  - The bit counter increments and saturates at WIDTH+1.
- **Transmit:**
  - CPHA=0: the first bit drives sdo from the cycle after nss-fall detection. Each shift edge advances one bit.
  - CPHA=1: sdo updates on every shift edge, including the first.
  - After WIDTH bits have been shifted out, sdo=0.
- **Frame end** (nss rise detected in ACTIVE):
  - Count == WIDTH and rx_valid==0 (or rx_ready==1 in the same cycle): rx_data ← shift register and rx_valid=1 on the next clk edge.
    - Latency: rx_valid rises SYNC_STAGES+1 clk edges after raw nss rise is first sampled.
  - Count == WIDTH and rx_valid==1 with rx_ready==0: the new frame is dropped, rx_data is kept, and rx_overrun pulses for 1 cycle.
  - Count ≠ WIDTH (including 0 or >WIDTH): rx_data and rx_valid are unchanged, and rx_len_err pulses for 1 cycle.
- **Handshake:**
  - rx_valid stays high until a cycle with rx_valid && rx_ready, then clears on the next edge.
  - If that handshake coincides with a valid frame end, the new data loads and rx_valid stays 1.
  - rx_data is stable while rx_valid=1.
- **Sampling at nss edges:** an sck edge detected in the same cycle as nss rise is ignored. An sck edge detected in the same cycle as nss fall is ignored.
- **Reset mid-frame:** rst wins over all events in that cycle. After release the block stays in WAIT_IDLE until nss is seen high.

Test Plan:
- Mode 0, WIDTH=16, master sends 16'hA5C3 → rx_data=16'hA5C3, rx_valid=1 exactly 3 clk after nss rise; rx_ready pulse clears rx_valid.
- Full duplex in all 4 CPOL/CPHA modes: tx_data=16'h1234 and master sends 16'hBEEF → master reads 16'h1234, rx_data=16'hBEEF.
  - Repeat with MSB_FIRST=0: master sends 0x0001 LSB-first and reads tx_data bits LSB-first.
- Two back-to-back frames 16'h0001, 16'h0002 with rx_ready=0 → rx_data stays 16'h0001, rx_overrun pulses once, rx_len_err=0.
- Frames of 15 and 17 bits → rx_len_err pulses each time, rx_valid stays 0; next 16-bit frame 16'hFFFF is received normally.
- rst asserted after 8 bits of a frame, then the master finishes 8 more bits → no rx_valid, no rx_len_err; next full frame 16'h5A5A is received.
- rx_ready high in the same cycle as frame end while rx_valid=1 → new data loaded, rx_valid stays 1, no overrun.
